// File: rtl/nw_bandless_scorer.sv
// Needleman-Wunsch global alignment scorer, one DP row per clock.
// Full-width rows (no band), saturating signed arithmetic throughout.
module nw_bandless_scorer #(
    parameter int MAXLEN   = 16,
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int INDEL    = -1,
    localparam int LW      = $clog2(MAXLEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [MAXLEN*CWIDTH-1:0]   s1,
    input  logic [MAXLEN*CWIDTH-1:0]   s2,
    input  logic [LW-1:0]              len1,
    input  logic [LW-1:0]              len2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SWIDTH-1:0]   score,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ROW,
        DONE
    } state_t;

    localparam logic signed [63:0] SMAX = (64'sd1 <<< (SWIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] SMIN = -(64'sd1 <<< (SWIDTH - 1));

    state_t r_state;
    state_t w_next;

    logic [MAXLEN*CWIDTH-1:0]  r_s1;
    logic [MAXLEN*CWIDTH-1:0]  r_s2;
    logic [LW-1:0]             r_len1;
    logic [LW-1:0]             r_len2;
    logic [LW-1:0]             r_i;
    logic signed [SWIDTH-1:0]  r_h [0:MAXLEN];
    logic signed [SWIDTH-1:0]  r_score;

    logic [LW-1:0]             w_l1;
    logic [LW-1:0]             w_l2;
    logic                      w_zero;
    logic [CWIDTH-1:0]         w_a;
    logic signed [SWIDTH-1:0]  w_new [0:MAXLEN];
    logic signed [SWIDTH-1:0]  w_fin;

    function automatic logic signed [SWIDTH-1:0] f_sat(
        input logic signed [63:0] v
    );
        logic signed [63:0] c;
        if (v > SMAX) begin
            c = SMAX;
        end else if (v < SMIN) begin
            c = SMIN;
        end else begin
            c = v;
        end
        return SWIDTH'(c);
    endfunction

    function automatic logic signed [SWIDTH-1:0] f_add(
        input logic signed [SWIDTH-1:0] a,
        input int                       b
    );
        return f_sat(64'(a) + 64'(b));
    endfunction

    // n * INDEL, clamped; equals n saturating additions of INDEL
    function automatic logic signed [SWIDTH-1:0] f_mul(
        input logic signed [63:0] n
    );
        return f_sat(n * 64'(INDEL));
    endfunction

    function automatic logic signed [SWIDTH-1:0] f_max(
        input logic signed [SWIDTH-1:0] a,
        input logic signed [SWIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign w_l1   = (len1 > LW'(MAXLEN)) ? LW'(MAXLEN) : len1;
    assign w_l2   = (len2 > LW'(MAXLEN)) ? LW'(MAXLEN) : len2;
    assign w_zero = (w_l1 == '0) || (w_l2 == '0);

    // Next DP row from the stored row; left-to-right chain in one cycle
    always_comb begin
        w_a = '0;
        for (int k = 0; k < MAXLEN; k++) begin
            if (r_i == LW'(k + 1)) begin
                w_a = r_s1[k*CWIDTH +: CWIDTH];
            end
        end
        w_new[0] = f_mul(64'($signed({1'b0, r_i})));
        for (int j = 1; j <= MAXLEN; j++) begin
            w_new[j] = f_max(
                f_max(f_add(r_h[j], INDEL), f_add(w_new[j-1], INDEL)),
                f_add(r_h[j-1],
                      (w_a == r_s2[(j-1)*CWIDTH +: CWIDTH]) ? MATCH : MISMATCH));
        end
    end

    assign w_fin = w_new[r_len2];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next = w_zero ? DONE : ROW;
                end
            end
            ROW: begin
                if (r_i == r_len1) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Job capture, row buffer update and final score
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_len1  <= '0;
            r_len2  <= '0;
            r_i     <= '0;
            r_score <= '0;
            for (int j = 0; j <= MAXLEN; j++) begin
                r_h[j] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s1   <= s1;
                        r_s2   <= s2;
                        r_len1 <= w_l1;
                        r_len2 <= w_l2;
                        r_i    <= LW'(1);
                        for (int j = 0; j <= MAXLEN; j++) begin
                            r_h[j] <= f_mul(64'(j));
                        end
                        if (w_zero) begin
                            r_score <= f_mul(64'($signed({1'b0, w_l1}))
                                           + 64'($signed({1'b0, w_l2})));
                        end
                    end
                end
                ROW: begin
                    for (int j = 0; j <= MAXLEN; j++) begin
                        r_h[j] <= w_new[j];
                    end
                    if (r_i == r_len1) begin
                        r_score <= w_fin;
                    end else begin
                        r_i <= r_i + LW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign score     = r_score;

endmodule

// File: tb/tb_nw_bandless_scorer.sv
// Bench for nw_bandless_scorer: default 16-bit and 4-bit score instances
// driven in parallel and compared against a full-matrix DP model.
module tb_nw_bandless_scorer;

    localparam int INDEL = -1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [31:0]        s1 = '0;
    logic [31:0]        s2 = '0;
    logic [4:0]         len1 = '0;
    logic [4:0]         len2 = '0;

    logic               ready_a, valid_a, busy_a;
    logic signed [15:0] score_a;
    logic               ready_b, valid_b, busy_b;
    logic signed [3:0]  score_b;

    int checks = 0;
    int failures = 0;

    nw_bandless_scorer u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ready_a),
        .s1(s1), .s2(s2), .len1(len1), .len2(len2),
        .out_valid(valid_a), .out_ready(out_ready),
        .score(score_a), .busy(busy_a)
    );

    nw_bandless_scorer #(.SWIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ready_b),
        .s1(s1), .s2(s2), .len1(len1), .len2(len2),
        .out_valid(valid_b), .out_ready(out_ready),
        .score(score_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cl(input int x);
        return (x > 16) ? 16 : x;
    endfunction

    function automatic longint clampv(input longint v, input int sw);
        longint hi, lo;
        hi = (64'sd1 <<< (sw - 1)) - 1;
        lo = -(64'sd1 <<< (sw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [31:0] pack(input string str);
        logic [31:0] v;
        v = $urandom;
        for (int k = 0; k < str.len(); k++) begin
            case (str[k])
                "A": v[k*2 +: 2] = 2'd0;
                "C": v[k*2 +: 2] = 2'd1;
                "G": v[k*2 +: 2] = 2'd2;
                "T": v[k*2 +: 2] = 2'd3;
                default: ;
            endcase
        end
        return v;
    endfunction

    function automatic longint model(input logic [31:0] a, input logic [31:0] b,
                                     input int l1, input int l2, input int sw);
        longint h [0:16][0:16];
        longint w;
        int n, m;
        n = cl(l1);
        m = cl(l2);
        if (n == 0 || m == 0) return clampv((n + m) * INDEL, sw);
        for (int j = 0; j <= m; j++) h[0][j] = clampv(j * INDEL, sw);
        for (int i = 1; i <= n; i++) begin
            h[i][0] = clampv(i * INDEL, sw);
            for (int j = 1; j <= m; j++) begin
                w = (a[(i-1)*2 +: 2] == b[(j-1)*2 +: 2]) ? 1 : -1;
                h[i][j] = clampv(h[i-1][j-1] + w, sw);
                if (clampv(h[i-1][j] + INDEL, sw) > h[i][j])
                    h[i][j] = clampv(h[i-1][j] + INDEL, sw);
                if (clampv(h[i][j-1] + INDEL, sw) > h[i][j])
                    h[i][j] = clampv(h[i][j-1] + INDEL, sw);
            end
        end
        return h[n][m];
    endfunction

    task automatic run_job(input string tag, input logic [31:0] v1, input logic [31:0] v2,
                           input int l1, input int l2, input int hold,
                           input longint exp_a, input longint exp_b);
        int cnt;
        int lat;
        lat = (cl(l1) == 0 || cl(l2) == 0) ? 0 : cl(l1);
        @(negedge clk);
        cnt = 0;
        while (!ready_a && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, ".ready"}, ready_a, 1);
        s1 = v1;
        s2 = v2;
        len1 = l1[4:0];
        len2 = l2[4:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s1 = $urandom;
        s2 = $urandom;
        len1 = 5'($urandom);
        len2 = 5'($urandom);
        cnt = 0;
        while (!valid_a && cnt < 100) begin
            chk({tag, ".row_ready"}, ready_a, 0);
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, ".latency"}, cnt, lat);
        chk({tag, ".score_a"}, score_a, exp_a);
        chk({tag, ".score_b"}, score_b, exp_b);
        chk({tag, ".valid_b"}, valid_b, 1);
        chk({tag, ".busy"}, busy_a, 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            s1 = $urandom;
            len1 = 5'($urandom);
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, valid_a, 1);
            chk({tag, ".hold_score"}, score_a, exp_a);
            chk({tag, ".hold_ready"}, ready_a, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, valid_a, 0);
        chk({tag, ".post_ready"}, ready_a, 1);
        chk({tag, ".post_busy_b"}, busy_b, 0);
    endtask

    initial begin
        logic [31:0] va, vb;
        int l1, l2;

        #1;
        chk("rst.ready", ready_a, 1);
        chk("rst.valid", valid_a, 0);
        chk("rst.busy", busy_a, 0);
        chk("rst.score", score_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        va = pack("ACGT");
        run_job("acgt", va, pack("ACGT"), 4, 4, 0, 4, 4);
        va = pack("ACG");
        vb = pack("AG");
        run_job("acg_ag", va, vb, 3, 2, 0, 1, model(va, vb, 3, 2, 4));
        va = pack("AC");
        vb = pack("CA");
        run_job("ac_ca", va, vb, 2, 2, 0, -1, model(va, vb, 2, 2, 4));
        va = pack("A");
        vb = pack("C");
        run_job("a_c", va, vb, 1, 1, 0, -1, -1);
        va = $urandom;
        run_job("len0", va, $urandom, 3, 0, 0, -3, -3);
        run_job("both0", va, $urandom, 0, 0, 0, 0, 0);
        va = $urandom;
        vb = $urandom;
        run_job("clamp20", va, vb, 20, 5, 0,
                model(va, vb, 16, 5, 16), model(va, vb, 16, 5, 4));
        va = pack("ACGT");
        run_job("hold5", va, pack("ACGT"), 4, 4, 5, 4, 4);
        va = $urandom;
        run_job("same16", va, va, 16, 16, 0, 16, 7);
        run_job("miss16", 32'h0000_0000, 32'h5555_5555, 16, 16, 0, -16, -8);

        @(negedge clk);
        s1 = pack("ACGT");
        s2 = pack("ACGT");
        len1 = 5'd4;
        len2 = 5'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst.valid", valid_a, 0);
        chk("midrst.busy", busy_a, 0);
        chk("midrst.ready", ready_a, 1);
        chk("midrst.score", score_a, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst.hold_valid", valid_a, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        va = pack("ACGT");
        run_job("after_rst", va, pack("ACGT"), 4, 4, 0, 4, 4);

        for (int n = 0; n < 12; n++) begin
            va = $urandom;
            vb = $urandom;
            l1 = $urandom_range(0, 20);
            l2 = $urandom_range(0, 20);
            run_job("rand", va, vb, l1, l2, $urandom_range(0, 2),
                    model(va, vb, l1, l2, 16), model(va, vb, l1, l2, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
